// File: rtl/mdu_iter.sv
// mdu_iter: iterative multiply/divide unit producing architectural HI/LO.
// One bit per cycle: MULTU/MULT by shift-add, DIVU/DIV by restoring division.
// Sign handling is done on magnitudes, then corrected in a single FIX cycle.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   start, op         launch request (sampled when idle); 00 MULTU 01 MULT 10 DIVU 11 DIV
//   a, b              operands (multiplicand/dividend, multiplier/divisor)
//   hi_we, lo_we      MTHI/MTLO strobes, honoured only when idle; wdata is the data
//   busy, done        operation in flight / one-cycle completion pulse
//   hi, lo            HI (product high / remainder), LO (product low / quotient)
module mdu_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned W2 = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

    state_e           state_q, state_d;
    logic [W2-1:0]    acc_q, acc_d;         // product, or remainder:quotient
    logic [WIDTH-1:0] mcand_q, mcand_d;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0] a_q, a_d;             // original dividend for divide-by-zero
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d; // operand signs differ (signed ops)
    logic             neg_rem_q, neg_rem_d; // dividend negative (DIV)
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             busy_q, busy_d, done_q, done_d;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   rem_sh;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_new;
    logic [W2-1:0]    prod;

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CALC;
            S_CALC:  if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        a_d       = a_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_q == S_FIX);

        mag_a   = (op[0] && a[WIDTH-1]) ? -a : a;
        mag_b   = (op[0] && b[WIDTH-1]) ? -b : b;
        // Shift-add step: W+1 bit sum keeps the carry that shifts into the top
        mul_sum = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
        // Restoring step: shifted partial remainder needs W+1 bits before the trial subtract
        rem_sh  = acc_q[W2-1:WIDTH-1];
        rem_ge  = (rem_sh >= {1'b0, mcand_q});
        rem_new = rem_ge ? WIDTH'(rem_sh - {1'b0, mcand_q}) : rem_sh[WIDTH-1:0];
        prod    = neg_res_q ? -acc_q : acc_q;

        case (state_q)
            S_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    is_div_d  = op[1];
                    a_d       = a;
                    cnt_d     = '0;
                    neg_res_d = op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d = op[0] & a[WIDTH-1];
                    dz_d      = op[1] & (b == '0);
                    if (op[1]) begin
                        acc_d   = {{WIDTH{1'b0}}, mag_a};
                        mcand_d = mag_b;
                    end else begin
                        acc_d   = {{WIDTH{1'b0}}, mag_b};
                        mcand_d = mag_a;
                    end
                end
            end
            S_CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (is_div_q) acc_d = {rem_new, acc_q[WIDTH-2:0], rem_ge};
                else          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            end
            S_FIX: begin
                if (!is_div_q) begin
                    hi_d = prod[W2-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (dz_q) begin
                    hi_d = a_q;
                    lo_d = '1;
                end else begin
                    lo_d = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = neg_rem_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            mcand_q   <= '0;
            a_q       <= '0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            a_q       <= a_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

endmodule

// File: tb/tb_mdu_iter.sv
// tb_mdu_iter: self-checking bench for mdu_iter against a plain-arithmetic HI/LO model.
module tb_mdu_iter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        hi_we = 1'b0, lo_we = 1'b0;
    logic [31:0] wdata = '0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int total = 0;
    int bad   = 0;

    mdu_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected {hi, lo} from the architectural definition of each op
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx, sy;
        logic [63:0] r;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            2'b00: r = 64'(x) * 64'(y);
            2'b01: r = 64'(sx * sy);
            2'b10: r = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            default: begin
                if (y == 0) r = {x, 32'hFFFF_FFFF};
                else begin
                    r[31:0]  = 32'(sx / sy);
                    r[63:32] = 32'(sx % sy);
                end
            end
        endcase
        return r;
    endfunction

    // Launch one op; optionally disturb it at cycle disturb_at and/or MTHI at the start edge
    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input int disturb_at, input logic hi_wr);
        logic [63:0] exp;
        logic [31:0] hold_hi;
        int          lat, bcnt;
        exp = model(o, x, y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y; hi_we = hi_wr; wdata = 32'h5A5A_0001;
        @(posedge clk); #1;
        start = 1'b0; hi_we = 1'b0;
        a = $urandom; b = $urandom; op = 2'($urandom);
        if (hi_wr) check({tag, "/mthi_with_start"}, 64'(hi), 64'h5A5A_0001);
        hold_hi = hi;
        lat  = -1;
        bcnt = 0;
        for (int i = 1; i <= 40; i++) begin
            if (busy) bcnt++;
            if (i == disturb_at) begin
                start = 1'b1; op = ~o; hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
            end
            @(posedge clk); #1;
            if (i == disturb_at) begin
                start = 1'b0; hi_we = 1'b0;
                check({tag, "/hi_held"}, 64'(hi), 64'(hold_hi));
            end
            if (done) begin
                lat = i;
                break;
            end
        end
        check({tag, "/latency"}, 64'(lat), 64'd33);
        check({tag, "/busy_cycles"}, 64'(bcnt), 64'd33);
        check({tag, "/busy_at_done"}, 64'(busy), 64'd0);
        check({tag, "/hi"}, 64'(hi), 64'(exp[63:32]));
        check({tag, "/lo"}, 64'(lo), 64'(exp[31:0]));
    endtask

    initial begin
        logic        seen;
        logic [1:0]  ro;
        logic [31:0] ra, rb;

        #12;
        check("rst/busy", 64'(busy), 64'd0);
        check("rst/done", 64'(done), 64'd0);
        check("rst/hi", 64'(hi), 64'd0);
        check("rst/lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
        @(posedge clk); #1;
        check("multu_max/done_once", 64'(done), 64'd0);
        run_op("mult_neg", 2'b01, 32'hFFFF_FFFD, 32'd5, 0, 1'b0);
        run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'd2, 0, 1'b0);
        run_op("divu_100_7", 2'b10, 32'd100, 32'd7, 0, 1'b0);
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
        run_op("divu_zero", 2'b10, 32'h1234_5678, 32'd0, 0, 1'b0);
        run_op("div_zero", 2'b11, 32'hFFFF_FFF0, 32'd0, 0, 1'b0);

        // Ignored start/MTHI while busy, then back-to-back start in the done cycle
        run_op("busy_ignore", 2'b01, 32'h0001_2345, 32'hFFFF_8000, 12, 1'b0);
        run_op("back_to_back", 2'b10, 32'hFFFF_FFFF, 32'd3, 0, 1'b0);

        @(negedge clk);
        lo_we = 1'b1; wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        lo_we = 1'b0;
        check("mtlo/lo", 64'(lo), 64'hCAFE_F00D);

        run_op("mthi_start", 2'b00, 32'h0000_1000, 32'h0000_0100, 0, 1'b1);

        // Reset in the middle of a MULT
        @(negedge clk);
        start = 1'b1; op = 2'b01; a = 32'h8765_4321; b = 32'h1357_9BDF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst/busy", 64'(busy), 64'd0);
        check("midrst/done", 64'(done), 64'd0);
        check("midrst/hi", 64'(hi), 64'd0);
        check("midrst/lo", 64'(lo), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        check("midrst/no_activity", 64'(seen), 64'd0);
        run_op("after_rst", 2'b01, 32'h8765_4321, 32'h1357_9BDF, 0, 1'b0);

        // Randomized ops with bias toward the boundary operands
        for (int n = 0; n < 40; n++) begin
            ro = 2'($urandom);
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: begin ra = 32'h8000_0000; rb = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : rb; end
                2: begin ra = 32'($urandom_range(0, 300)); rb = 32'($urandom_range(1, 20)); end
                3: rb = -32'($urandom_range(1, 20));
                default: ;
            endcase
            run_op("rand", ro, ra, rb, (n % 4 == 0) ? 1 + (n % 30) : 0, 1'(n % 5 == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
